database_tx_sequencer: RTL
==========================

Name: database_tx_sequencer

Overview:
- Sequences the MIPS debug dump to the PC over UART.
- On a start pulse from debug_unit, it walks the database field selects 1..CANT_CAMPOS (PC, cycle counter, PC+4, fetched instruction).
- It captures each 32-bit field, splits it into bytes, and drives tx with a start/done handshake, most significant byte first.
- It sits between debug_unit, database and tx, and owns o_control_database and the tx start/data lines while a dump runs.

Parameters:
- LONGITUD_INSTRUCCION, 32, width of a database word.
- OUTPUT_WORD_LENGTH, 8, UART byte width; must divide LONGITUD_INSTRUCCION.
- CANT_BITS_CONTROL, 3, width of the database select.
- CANT_CAMPOS, 4, number of fields sent per dump; must be below 2^CANT_BITS_CONTROL.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_soft_reset  in  1  synchronous abort, active high.
- i_start  in  1  dump request, sampled only in IDLE.
- i_dato_database  in  LONGITUD_INSTRUCCION  registered database output. Valid 1 cycle after its select changes.
- i_tx_done  in  1  1-cycle pulse from tx when a byte has finished.
- o_control_database  out  CANT_BITS_CONTROL  field select; 0 means no field selected.
- o_tx_start  out  1  1-cycle pulse to tx.
- o_data_tx  out  OUTPUT_WORD_LENGTH  byte to transmit, stable from o_tx_start until i_tx_done.
- o_busy  out  1  high from the first state after IDLE through the cycle before DONE.
- o_done  out  1  1-cycle pulse when the dump is complete.

Behaviour:
- All outputs are registered.
- Reset values: o_control_database=0, o_tx_start=0, o_data_tx=0, o_busy=0, o_done=0; state IDLE; field=0, byte_cnt=0, shreg=0.
- Derived constant: BYTES = LONGITUD_INSTRUCCION/OUTPUT_WORD_LENGTH (4 at the defaults).
- FSM states: IDLE, SELECT, WAIT_DATA, WAIT_TX, DONE.
- IDLE:
  - On i_start: field=1, o_control_database=1, o_busy=1, go to SELECT.
  - Otherwise stay in IDLE.
- SELECT: one settle cycle while the database registers the new field; go to WAIT_DATA.
- WAIT_DATA:
  - shreg <= i_dato_database; o_data_tx <= i_dato_database top byte.
  - o_tx_start=1 for one cycle; byte_cnt=0; go to WAIT_TX.
- WAIT_TX, without i_tx_done: hold o_data_tx, o_tx_start=0.
- WAIT_TX, on i_tx_done with byte_cnt < BYTES-1:
  - shreg shifted left by OUTPUT_WORD_LENGTH; o_data_tx = next byte.
  - o_tx_start pulses; byte_cnt++; stay in WAIT_TX.
- WAIT_TX, on i_tx_done with the last byte of a non-final field: field++, o_control_database=field+1, go to SELECT.
- WAIT_TX, on i_tx_done with the last byte of field CANT_CAMPOS: o_control_database=0, o_busy=0, o_done=1, go to DONE.
- DONE: o_done=0, go to IDLE. i_start is ignored in DONE.
- Latency:
  - i_start sampled at edge 0 gives the first o_tx_start after edge 2.
  - Each later byte's o_tx_start follows its i_tx_done by exactly 1 edge.
  - Between fields, tx_start comes 3 edges after the last tx_done.
- Boundary conditions:
  - i_start while busy: ignored, no queuing.
  - i_tx_done outside WAIT_TX, or while o_tx_start is high: ignored.
  - o_tx_start is never asserted twice without an intervening accepted i_tx_done.
  - i_soft_reset has priority over all transitions and returns every register to its reset value on the next edge. A byte already handed to tx is not recalled.
  - i_reset low: all registers clear immediately, independent of the clock.
  - A change in i_dato_database after capture has no effect until the next field's WAIT_DATA.
  - Counter widths: field uses CANT_BITS_CONTROL bits; byte_cnt uses clog2(BYTES) bits, minimum 1. No wrap occurs within legal parameters.

Decomposition:
- Shared package (or defines header), alongside the existing top-level defines:
  - state encodings ST_IDLE, ST_SELECT, ST_WAIT_DATA, ST_WAIT_TX, ST_DONE (3 bits).
  - DB_SEL_NONE=0.
  - field codes DB_SEL_PC=1, DB_SEL_CICLOS=2, DB_SEL_PC4=3, DB_SEL_INSTR=4.
- Natural sub-module: word_byte_serializer, holding shreg, byte_cnt and o_data_tx. Its interface is load, shift, last_byte and byte_out. The FSM stays in the parent.

Test Plan:
- Reset then idle: hold i_reset=0 for 3 cycles, release, no i_start for 10 cycles → all outputs 0, o_busy stays 0.
- Full dump: database model returns 0x11223344, 0x00000005, 0x55667788, 0xFC000000 for selects 1..4; tx model returns i_tx_done 5 cycles after each o_tx_start.
  - o_data_tx sequence: 11,22,33,44, 00,00,00,05, 55,66,77,88, FC,00,00,00.
  - Exactly 16 tx_start pulses, then one o_done pulse, then o_control_database=0.
- Timing check: i_start at edge 0 → o_control_database=1 after edge 0 and first o_tx_start after edge 2. Each later byte's o_tx_start follows its i_tx_done by exactly 1 edge. Between fields, tx_start comes 3 edges after the last tx_done.
- Busy/spurious inputs: pulse i_start during byte 2, and inject i_tx_done while in SELECT → byte stream unchanged (still 16 bytes), single o_done.
- Soft abort: assert i_soft_reset while byte 3 of field 2 is pending → next cycle all outputs 0 and state IDLE. A new i_start then restarts at field 1, byte 11.
- Async reset mid-dump: drive i_reset low between clock edges during WAIT_TX → outputs clear before the next edge; no tx_start occurs after release until a new i_start.

Source files
------------

// File: rtl/database_tx_sequencer_pkg.sv
// Shared types and constants for the MIPS debug-dump sequencer.
// Holds FSM state encodings and the database field select codes.
package database_tx_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SELECT    = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_WAIT_TX   = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam logic [2:0] DB_SEL_NONE   = 3'd0;
    localparam logic [2:0] DB_SEL_PC     = 3'd1;
    localparam logic [2:0] DB_SEL_CICLOS = 3'd2;
    localparam logic [2:0] DB_SEL_PC4    = 3'd3;
    localparam logic [2:0] DB_SEL_INSTR  = 3'd4;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/database_tx_sequencer_if.sv
// Handshake bundle between the dump sequencer, debug_unit,
// the database and the UART transmitter.
interface database_tx_sequencer_if #(
    parameter int LONGITUD_INSTRUCCION = 32,
    parameter int OUTPUT_WORD_LENGTH   = 8,
    parameter int CANT_BITS_CONTROL    = 3
);

    logic                            i_soft_reset;
    logic                            i_start;
    logic [LONGITUD_INSTRUCCION-1:0] i_dato_database;
    logic                            i_tx_done;
    logic [CANT_BITS_CONTROL-1:0]    o_control_database;
    logic                            o_tx_start;
    logic [OUTPUT_WORD_LENGTH-1:0]   o_data_tx;
    logic                            o_busy;
    logic                            o_done;

    modport master (
        output i_soft_reset,
        output i_start,
        output i_dato_database,
        output i_tx_done,
        input  o_control_database,
        input  o_tx_start,
        input  o_data_tx,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_soft_reset,
        input  i_start,
        input  i_dato_database,
        input  i_tx_done,
        output o_control_database,
        output o_tx_start,
        output o_data_tx,
        output o_busy,
        output o_done
    );

endinterface

// File: rtl/database_tx_sequencer_word_byte_serializer.sv
// Splits a captured database word into bytes, MSB first.
// load/shift/clear are mutually exclusive by construction in the parent.
module word_byte_serializer
    import database_tx_sequencer_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int BYTE_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [WORD_W-1:0] word_i,
    output logic              last_byte_o,
    output logic [BYTE_W-1:0] byte_o
);

    localparam int BYTES = WORD_W / BYTE_W;
    localparam int CNT_W = cnt_width(BYTES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

    logic [WORD_W-1:0] shreg_q, shreg_d, shifted;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BYTE_W-1:0] byte_q, byte_d;

    assign shifted = shreg_q << BYTE_W;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        unique case (1'b1)
            clear_i: begin
                shreg_d = '0;
                cnt_d   = '0;
                byte_d  = '0;
            end
            load_i: begin
                shreg_d = word_i;
                cnt_d   = '0;
                byte_d  = word_i[WORD_W-1 -: BYTE_W];
            end
            shift_i: begin
                shreg_d = shifted;
                cnt_d   = cnt_q + 1'b1;
                byte_d  = shifted[WORD_W-1 -: BYTE_W];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
        end
    end

    assign last_byte_o = (cnt_q == LAST);
    assign byte_o      = byte_q;

endmodule

// File: rtl/database_tx_sequencer.sv
// Walks the database fields on a start pulse and streams each
// 32-bit word to the UART transmitter, most significant byte first.
module database_tx_sequencer
    import database_tx_sequencer_pkg::*;
#(
    parameter int LONGITUD_INSTRUCCION = 32,
    parameter int OUTPUT_WORD_LENGTH   = 8,
    parameter int CANT_BITS_CONTROL    = 3,
    parameter int CANT_CAMPOS          = 4
) (
    input logic                   i_clock,
    input logic                   i_reset,
    database_tx_sequencer_if.slave bus
);

    localparam int CB = CANT_BITS_CONTROL;
    localparam logic [CB-1:0] FIRST_FIELD = CB'(DB_SEL_PC);
    localparam logic [CB-1:0] LAST_FIELD  = CB'(CANT_CAMPOS);
    localparam logic [CB-1:0] SEL_NONE    = CB'(DB_SEL_NONE);

    state_t        state_q;
    logic [CB-1:0] field_q;
    logic [CB-1:0] ctrl_q;
    logic          start_q;
    logic          busy_q;
    logic          done_q;

    logic done_ok;
    logic last_byte;
    logic ser_load;
    logic ser_shift;

    // A done pulse coinciding with our own start pulse belongs to no byte.
    assign done_ok   = bus.i_tx_done && !start_q && (state_q == ST_WAIT_TX);
    assign ser_load  = (state_q == ST_WAIT_DATA) && !bus.i_soft_reset;
    assign ser_shift = done_ok && !last_byte && !bus.i_soft_reset;

    word_byte_serializer #(
        .WORD_W (LONGITUD_INSTRUCCION),
        .BYTE_W (OUTPUT_WORD_LENGTH)
    ) u_ser (
        .clk_i       (i_clock),
        .rst_ni      (i_reset),
        .clear_i     (bus.i_soft_reset),
        .load_i      (ser_load),
        .shift_i     (ser_shift),
        .word_i      (bus.i_dato_database),
        .last_byte_o (last_byte),
        .byte_o      (bus.o_data_tx)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            field_q <= '0;
            ctrl_q  <= SEL_NONE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.i_soft_reset) begin
            state_q <= ST_IDLE;
            field_q <= '0;
            ctrl_q  <= SEL_NONE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        field_q <= FIRST_FIELD;
                        ctrl_q  <= FIRST_FIELD;
                        busy_q  <= 1'b1;
                        state_q <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    state_q <= ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    start_q <= 1'b1;
                    state_q <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (done_ok) begin
                        if (!last_byte) begin
                            start_q <= 1'b1;
                        end else if (field_q != LAST_FIELD) begin
                            field_q <= field_q + 1'b1;
                            ctrl_q  <= field_q + 1'b1;
                            state_q <= ST_SELECT;
                        end else begin
                            ctrl_q  <= SEL_NONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_control_database = ctrl_q;
    assign bus.o_tx_start         = start_q;
    assign bus.o_busy             = busy_q;
    assign bus.o_done             = done_q;

endmodule
